// File: rtl/higher_or_lower_pkg.sv
// Shared types and constants for the Higher-or-Lower game controller.
//   state_t      : FSM state encoding (exported on the 3-bit state port)
//   BLUE..RED    : {r,g,b} drive values for the onboard RGB LED
//   GUESS_*      : latched guess codes; GUESS_NONE marks a timed-out (forced miss) round
//   lfsr_taps()  : Galois feedback masks for maximal-length LFSRs
package higher_or_lower_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAL      = 3'd1,
        GUESS     = 3'd2,
        DRAW      = 3'd3,
        CHECK     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [1:0] GUESS_HI   = 2'b10;
    localparam logic [1:0] GUESS_LO   = 2'b01;
    localparam logic [1:0] GUESS_NONE = 2'b00;

    // Right-shifting Galois masks: term x^k of the feedback polynomial maps to bit k-1.
    // Widths 2..16 and 32 are covered; other widths do not give a maximal sequence.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/higher_or_lower_game_ctrl_lfsr_rng.sv
// Maximal-length Galois LFSR used as the card source. Advances every cycle out of reset.
//   clk    in  : system clock
//   reset  in  : synchronous, active-low; loads SEED (a zero seed becomes 1)
//   value  out : current LFSR state, WIDTH bits (WIDTH >= 2)
module lfsr_rng
    import higher_or_lower_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] value
);

    localparam logic [31:0]      TAPS32  = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAPS32[WIDTH-1:0];
    // An all-zero state would lock the register, so it can never be loaded.
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (!reset)
            value <= SEED_NZ;
        else if (value[0])
            value <= (value >> 1) ^ TAPS;
        else
            value <= value >> 1;
    end

endmodule

// File: rtl/higher_or_lower_game_ctrl.sv
// Higher-or-Lower game controller: deals a card, takes a higher/lower guess, draws the next
// card and scores it. Tracks lives, a saturating score, a high score and an optional timeout.
//   clk, reset           : system clock, synchronous active-low reset
//   higher_btn/lower_btn : debounced levels; rising edges make a guess
//   confirm_btn          : debounced level; rising edge starts a game
//   state                : FSM state (encoding in higher_or_lower_pkg)
//   cur_num / next_num   : shown card / last drawn card
//   score / high_score   : current game score (saturating) / best since reset
//   lives_left           : remaining lives
//   rgb_led              : {r,g,b} LED drive
//   round_done/round_win : pulse while a guess is scored / its outcome, held afterwards
module higher_or_lower_game_ctrl
    import higher_or_lower_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               SCORE_W        = 8,
    parameter int               LIVES          = 3,
    parameter bit               TIE_WINS       = 1'b1,
    parameter int               TIMEOUT_CYCLES = 0,
    parameter logic [WIDTH-1:0] LFSR_SEED      = WIDTH'(8'hA5)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       higher_btn,
    input  logic                       lower_btn,
    input  logic                       confirm_btn,
    output logic [2:0]                 state,
    output logic [WIDTH-1:0]           cur_num,
    output logic [WIDTH-1:0]           next_num,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         high_score,
    output logic [$clog2(LIVES+1)-1:0] lives_left,
    output logic [2:0]                 rgb_led,
    output logic                       round_done,
    output logic                       round_win
);

    localparam int              LW         = $clog2(LIVES + 1);
    localparam int              TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [LW-1:0]   LIVES_INIT = LW'(LIVES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             cur_state, nxt_state;
    logic [WIDTH-1:0]   rnd;
    logic               higher_prev, lower_prev, confirm_prev;
    logic               armed;
    logic               hi_rise, lo_rise, confirm_rise;
    logic               guess_hi, guess_lo, guess_any;
    logic [1:0]         guess_q;
    logic [TMO_W-1:0]   tmo;
    logic               timed_out;
    logic               win, win_hold;

    lfsr_rng #(.WIDTH(WIDTH), .SEED(LFSR_SEED)) u_rng (
        .clk   (clk),
        .reset (reset),
        .value (rnd)
    );

    // The prev registers clear in reset, so a button held through reset would look like a
    // fresh rise; 'armed' masks edges for the first cycle after reset while prev catches up.
    assign hi_rise      = armed & higher_btn  & ~higher_prev;
    assign lo_rise      = armed & lower_btn   & ~lower_prev;
    assign confirm_rise = armed & confirm_btn & ~confirm_prev;

    // Simultaneous higher and lower rises are ambiguous and dropped.
    assign guess_hi  = hi_rise & ~lo_rise;
    assign guess_lo  = lo_rise & ~hi_rise;
    assign guess_any = guess_hi | guess_lo;

    assign timed_out = TMO_EN && (tmo == TMO_LAST);

    // A timed-out round carries GUESS_NONE and therefore always scores as a loss.
    always_comb begin
        win = 1'b0;
        if (guess_q == GUESS_HI)
            win = (next_num > cur_num) || (TIE_WINS && (next_num == cur_num));
        else if (guess_q == GUESS_LO)
            win = (next_num < cur_num) || (TIE_WINS && (next_num == cur_num));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    // Next-state logic
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:      if (confirm_rise) nxt_state = DEAL;
            DEAL:      nxt_state = GUESS;
            GUESS: begin
                if (guess_any)      nxt_state = DRAW;
                else if (timed_out) nxt_state = CHECK;
            end
            DRAW:      nxt_state = CHECK;
            CHECK:     nxt_state = (!win && lives_left <= LW'(1)) ? GAME_OVER : GUESS;
            GAME_OVER: if (confirm_rise) nxt_state = DEAL;
            default:   nxt_state = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        state      = cur_state;
        round_done = (cur_state == CHECK);
        round_win  = (cur_state == CHECK) ? win : win_hold;
    end

    // Datapath: edge registers, cards, counters and LED
    always_ff @(posedge clk) begin
        if (!reset) begin
            higher_prev  <= 1'b0;
            lower_prev   <= 1'b0;
            confirm_prev <= 1'b0;
            armed        <= 1'b0;
            cur_num      <= '0;
            next_num     <= '0;
            score        <= '0;
            high_score   <= '0;
            lives_left   <= LIVES_INIT;
            rgb_led      <= BLUE;
            guess_q      <= GUESS_NONE;
            tmo          <= '0;
            win_hold     <= 1'b0;
        end else begin
            higher_prev  <= higher_btn;
            lower_prev   <= lower_btn;
            confirm_prev <= confirm_btn;
            armed        <= 1'b1;
            case (cur_state)
                IDLE: rgb_led <= BLUE;
                DEAL: begin
                    cur_num    <= rnd;
                    score      <= '0;
                    lives_left <= LIVES_INIT;
                    tmo        <= '0;
                    rgb_led    <= WHITE;
                end
                GUESS: begin
                    if (guess_any)
                        guess_q <= guess_hi ? GUESS_HI : GUESS_LO;
                    else if (timed_out)
                        guess_q <= GUESS_NONE;
                    if (TMO_EN && !guess_any)
                        tmo <= tmo + 1'b1;
                end
                DRAW: next_num <= rnd;
                CHECK: begin
                    tmo      <= '0;
                    win_hold <= win;
                    if (win) begin
                        if (score != '1)
                            score <= score + 1'b1;
                        rgb_led <= GREEN;
                        cur_num <= next_num;
                    end else if (lives_left > LW'(1)) begin
                        lives_left <= lives_left - 1'b1;
                        rgb_led    <= YELLOW;
                        cur_num    <= next_num;
                    end else begin
                        // Last life lost: the score is final, fold it into the high score.
                        lives_left <= '0;
                        rgb_led    <= RED;
                        if (score > high_score)
                            high_score <= score;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_higher_or_lower_game_ctrl.sv
module tb_higher_or_lower_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hb = 1'b0, lb = 1'b0, cb = 1'b0;   // shared by dut_a and dut_b
    logic hc = 1'b0, lc = 1'b0, cc = 1'b0;   // dut_c only

    logic [2:0] a_state, b_state, c_state;
    logic [7:0] a_cur, a_next, b_cur, b_next, c_cur, c_next;
    logic [7:0] a_score, a_hs, c_score, c_hs;
    logic [1:0] b_score, b_hs;
    logic [1:0] a_lives, b_lives, c_lives;
    logic [2:0] a_rgb, b_rgb, c_rgb;
    logic       a_rd, a_rw, b_rd, b_rw, c_rd, c_rw;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m;        // model of the DUT LFSR value during the current cycle
    logic [7:0] exp_cur;  // model of cur_num for dut_a / dut_b

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    always @(posedge clk) m <= !reset ? 8'hA5 : lfsr_step(m);

    higher_or_lower_game_ctrl #(.WIDTH(8), .SCORE_W(8), .LIVES(3), .TIE_WINS(1'b1),
        .TIMEOUT_CYCLES(0), .LFSR_SEED(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .higher_btn(hb), .lower_btn(lb), .confirm_btn(cb),
        .state(a_state), .cur_num(a_cur), .next_num(a_next), .score(a_score),
        .high_score(a_hs), .lives_left(a_lives), .rgb_led(a_rgb),
        .round_done(a_rd), .round_win(a_rw));

    higher_or_lower_game_ctrl #(.WIDTH(8), .SCORE_W(2), .LIVES(3), .TIE_WINS(1'b0),
        .TIMEOUT_CYCLES(0), .LFSR_SEED(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .higher_btn(hb), .lower_btn(lb), .confirm_btn(cb),
        .state(b_state), .cur_num(b_cur), .next_num(b_next), .score(b_score),
        .high_score(b_hs), .lives_left(b_lives), .rgb_led(b_rgb),
        .round_done(b_rd), .round_win(b_rw));

    higher_or_lower_game_ctrl #(.WIDTH(8), .SCORE_W(8), .LIVES(3), .TIE_WINS(1'b1),
        .TIMEOUT_CYCLES(10), .LFSR_SEED(8'hA5)) dut_c (
        .clk(clk), .reset(reset), .higher_btn(hc), .lower_btn(lc), .confirm_btn(cc),
        .state(c_state), .cur_num(c_cur), .next_num(c_next), .score(c_score),
        .high_score(c_hs), .lives_left(c_lives), .rgb_led(c_rgb),
        .round_done(c_rd), .round_win(c_rw));

    // ---- stimulus helpers (no checking) ----
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle button pulse on the a/b set; returns in the cycle after the sampling edge.
    task automatic press_ab(input logic h, input logic l, input logic c);
        hb = h; lb = l; cb = c;
        tick(1);
        hb = 1'b0; lb = 1'b0; cb = 1'b0;
    endtask

    // Confirm from IDLE/GAME_OVER; returns in the first GUESS cycle.
    task automatic start_ab();
        press_ab(1'b0, 1'b0, 1'b1);
        exp_cur = m;              // DEAL cycle: cur_num takes this value
        tick(1);
    endtask

    // Makes a guess that wins (or loses) against the predicted draw; returns in the CHECK cycle.
    task automatic guess_ab(input bit want_win, output logic [7:0] drawn);
        logic [7:0] nxt;
        logic       hi;
        for (int i = 0; i < 4 && lfsr_step(m) == exp_cur; i++) tick(1);
        nxt = lfsr_step(m);
        hi  = ((nxt > exp_cur) == want_win);
        press_ab(hi, !hi, 1'b0);
        drawn = nxt;
        tick(1);
    endtask

    task automatic play_ab(input int wins, input int losses);
        logic [7:0] d;
        for (int i = 0; i < wins; i++) begin
            guess_ab(1'b1, d); tick(1); exp_cur = d;
        end
        for (int i = 0; i < losses; i++) begin
            guess_ab(1'b0, d); tick(1);
            if (i < losses - 1) exp_cur = d;
        end
    endtask

    // ---- tests ----
    task automatic test_reset();
        reset = 1'b0; cb = 1'b1; cc = 1'b1;   // confirm held through reset
        tick(2);
        reset = 1'b1;
        tick(3);
        n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", a_state); end
        n_cmp++; if (a_cur !== 8'h00 || a_next !== 8'h00) begin n_bad++; $display("FAIL reset_nums got=%h/%h exp=00/00", a_cur, a_next); end
        n_cmp++; if (a_score !== 8'd0 || a_hs !== 8'd0) begin n_bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", a_score, a_hs); end
        n_cmp++; if (a_lives !== 2'd3) begin n_bad++; $display("FAIL reset_lives got=%0d exp=3", a_lives); end
        n_cmp++; if (a_rgb !== 3'b001) begin n_bad++; $display("FAIL reset_rgb got=%b exp=001", a_rgb); end
        n_cmp++; if (a_rd !== 1'b0 || a_rw !== 1'b0) begin n_bad++; $display("FAIL reset_round got=%b%b exp=00", a_rd, a_rw); end
        n_cmp++; if (c_state !== 3'd0) begin n_bad++; $display("FAIL held_confirm_c got=%0d exp=0", c_state); end
        cb = 1'b0; cc = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_game();
        start_ab();
        n_cmp++; if (a_rgb !== 3'b111 || a_cur !== exp_cur) begin n_bad++; $display("FAIL deal got rgb=%b cur=%h exp rgb=111 cur=%h", a_rgb, a_cur, exp_cur); end
        play_ab(2, 0);
        n_cmp++; if (a_score !== 8'd2 || a_state !== 3'd2) begin n_bad++; $display("FAIL mid_pre got score=%0d state=%0d exp 2/2", a_score, a_state); end
        reset = 1'b0; tick(1); reset = 1'b1;
        n_cmp++; if (a_state !== 3'd0 || a_score !== 8'd0 || a_hs !== 8'd0) begin n_bad++; $display("FAIL mid_reset got state=%0d score=%0d hs=%0d exp 0/0/0", a_state, a_score, a_hs); end
        n_cmp++; if (a_rgb !== 3'b001 || a_lives !== 2'd3) begin n_bad++; $display("FAIL mid_reset_led got rgb=%b lives=%0d exp 001/3", a_rgb, a_lives); end
        tick(1);
    endtask

    task automatic test_tie();
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) if (lfsr_step(m) == 8'h40) found = 1; else tick(1);
        start_ab();
        n_cmp++; if (a_cur !== 8'h40) begin n_bad++; $display("FAIL tie_deal got=%h exp=40", a_cur); end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) if (lfsr_step(m) == 8'h40) found = 1; else tick(1);
        n_cmp++; if (!found) begin n_bad++; $display("FAIL tie_wait got=timeout exp=draw 40"); end
        press_ab(1'b0, 1'b1, 1'b0);
        tick(1);
        n_cmp++; if (a_state !== 3'd4 || a_rd !== 1'b1 || a_rw !== 1'b1) begin n_bad++; $display("FAIL tie_win got state=%0d rd=%b rw=%b exp 4/1/1", a_state, a_rd, a_rw); end
        n_cmp++; if (b_rd !== 1'b1 || b_rw !== 1'b0) begin n_bad++; $display("FAIL tie_lose got rd=%b rw=%b exp 1/0", b_rd, b_rw); end
        tick(1);
        n_cmp++; if (a_score !== 8'd1 || a_rgb !== 3'b010 || a_next !== 8'h40) begin n_bad++; $display("FAIL tie_a got score=%0d rgb=%b next=%h exp 1/010/40", a_score, a_rgb, a_next); end
        n_cmp++; if (b_lives !== 2'd2 || b_rgb !== 3'b110 || b_score !== 2'd0) begin n_bad++; $display("FAIL tie_b got lives=%0d rgb=%b score=%0d exp 2/110/0", b_lives, b_rgb, b_score); end
        n_cmp++; if (a_rd !== 1'b0 || a_rw !== 1'b1) begin n_bad++; $display("FAIL tie_hold got rd=%b rw=%b exp 0/1", a_rd, a_rw); end
        exp_cur = 8'h40;
    endtask

    task automatic test_score_sat();
        logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [7:0] exp_a [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            guess_ab(1'b1, d);
            tick(1);
            exp_cur = d;
            n_cmp++; if (b_score !== exp_b[i]) begin n_bad++; $display("FAIL sat_b[%0d] got=%0d exp=%0d", i, b_score, exp_b[i]); end
            n_cmp++; if (a_score !== exp_a[i] || a_cur !== exp_cur) begin n_bad++; $display("FAIL sat_a[%0d] got score=%0d cur=%h exp %0d/%h", i, a_score, a_cur, exp_a[i], exp_cur); end
        end
    endtask

    task automatic test_lives();
        logic [1:0] exp_a [3] = '{2'd2, 2'd1, 2'd0};
        logic [1:0] exp_b [3] = '{2'd1, 2'd0, 2'd0};
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            guess_ab(1'b0, d);
            n_cmp++; if (a_rd !== 1'b1 || a_rw !== 1'b0) begin n_bad++; $display("FAIL lives_round[%0d] got rd=%b rw=%b exp 1/0", i, a_rd, a_rw); end
            tick(1);
            if (i < 2) exp_cur = d;
            n_cmp++; if (a_lives !== exp_a[i] || b_lives !== exp_b[i]) begin n_bad++; $display("FAIL lives[%0d] got a=%0d b=%0d exp %0d/%0d", i, a_lives, b_lives, exp_a[i], exp_b[i]); end
        end
        n_cmp++; if (a_state !== 3'd5 || a_rgb !== 3'b100 || a_hs !== 8'd6) begin n_bad++; $display("FAIL over_a got state=%0d rgb=%b hs=%0d exp 5/100/6", a_state, a_rgb, a_hs); end
        n_cmp++; if (b_state !== 3'd5 || b_hs !== 2'd3) begin n_bad++; $display("FAIL over_b got state=%0d hs=%0d exp 5/3", b_state, b_hs); end
        press_ab(1'b1, 1'b0, 1'b0); tick(1);
        press_ab(1'b0, 1'b1, 1'b0); tick(2);
        n_cmp++; if (a_state !== 3'd5 || a_lives !== 2'd0) begin n_bad++; $display("FAIL over_ignore got state=%0d lives=%0d exp 5/0", a_state, a_lives); end
    endtask

    task automatic test_high_score();
        reset = 1'b0; tick(1); reset = 1'b1; tick(1);
        start_ab();
        play_ab(2, 3);
        n_cmp++; if (a_state !== 3'd5 || a_hs !== 8'd2) begin n_bad++; $display("FAIL hs_game1 got state=%0d hs=%0d exp 5/2", a_state, a_hs); end
        start_ab();
        n_cmp++; if (a_score !== 8'd0 || a_lives !== 2'd3 || a_hs !== 8'd2) begin n_bad++; $display("FAIL hs_redeal got score=%0d lives=%0d hs=%0d exp 0/3/2", a_score, a_lives, a_hs); end
        press_ab(1'b1, 1'b1, 1'b0);
        n_cmp++; if (a_state !== 3'd2) begin n_bad++; $display("FAIL both_btn got=%0d exp=2", a_state); end
        tick(1);
        play_ab(1, 3);
        n_cmp++; if (a_score !== 8'd1 || a_hs !== 8'd2 || a_state !== 3'd5) begin n_bad++; $display("FAIL hs_game2 got score=%0d hs=%0d state=%0d exp 1/2/5", a_score, a_hs, a_state); end
    endtask

    task automatic test_timeout();
        cc = 1'b1; tick(1); cc = 1'b0;   // now in DEAL
        tick(1);                         // first GUESS cycle
        n_cmp++; if (c_state !== 3'd2) begin n_bad++; $display("FAIL tmo_entry got=%0d exp=2", c_state); end
        tick(9);
        n_cmp++; if (c_state !== 3'd2) begin n_bad++; $display("FAIL tmo_early got=%0d exp=2", c_state); end
        tick(1);
        n_cmp++; if (c_state !== 3'd4 || c_rd !== 1'b1 || c_rw !== 1'b0) begin n_bad++; $display("FAIL tmo_check got state=%0d rd=%b rw=%b exp 4/1/0", c_state, c_rd, c_rw); end
        tick(1);
        n_cmp++; if (c_lives !== 2'd2 || c_rgb !== 3'b110 || c_state !== 3'd2) begin n_bad++; $display("FAIL tmo_after got lives=%0d rgb=%b state=%0d exp 2/110/2", c_lives, c_rgb, c_state); end
    endtask

    task automatic test_no_timeout();
        start_ab();
        tick(1000);
        n_cmp++; if (a_state !== 3'd2 || a_lives !== 2'd3) begin n_bad++; $display("FAIL no_tmo got state=%0d lives=%0d exp 2/3", a_state, a_lives); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=time limit exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_game();
        test_tie();
        test_score_sat();
        test_lives();
        test_high_score();
        test_timeout();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
